fifo_wr_ctrl: RTL
=================

// Module: fifo_wr_ctrl
// PURPOSE
// - Write-side initiator for the async FIFO. Owns the w_clk domain ahead of the w_full pointer/flag block.
// - Accepts upstream words via valid/ready into a 2-entry skid buffer.
// - Issues w_en/w_addr/w_data to the dual-port RAM and w_full, honouring full.
// - Synchronises the read-domain gray pointer into w_clk (feeds w_full.r_count_sync) and frames packets.
// PARAMETERS
// - DATA_W       8   RAM word width
// - ADDR_W       7   RAM address width (= w_count width)
// - PTR_W        8   gray pointer width (ADDR_W+1)
// - SYNC_STAGES  2   flop stages on rptr_gray crossing, >=2
// - LEN_W        16  packet length counter width
// PORTS
// - w_clk         in   1       write-domain clock
// - n_rst         in   1       async reset, active-low
// - in_valid      in   1       upstream word valid
// - in_data       in   DATA_W  upstream word
// - in_last       in   1       upstream word ends packet
// - in_ready      out  1       skid buffer can accept
// - full          in   1       from w_full, registered full flag
// - w_count       in   ADDR_W  from w_full, current write address
// - rptr_gray     in   PTR_W   read pointer, gray, r_clk domain (async)
// - r_count_sync  out  PTR_W   synchronised rptr to w_full
// - w_en          out  1       RAM write strobe / w_full increment
// - w_addr        out  ADDR_W  RAM write address
// - w_data        out  DATA_W  RAM write data
// - pkt_done      out  1       1-cycle pulse: packet's last word written
// - pkt_len       out  LEN_W   word count of the completed packet, valid with pkt_done
// BEHAVIOUR
// - Reset: n_rst is asynchronous, active-low; clock is w_clk.
//   - Registered outputs reset to 0: sync stages, r_count_sync, skid occupancy, pkt_done, pkt_len, length counter.
//   - FSM resets to IDLE.
//   - in_ready = 1 out of reset (occ=0). w_en = 0 out of reset.
// - Reset mid-packet: buffered words and the partial count are discarded. No pkt_done is issued for that packet.
// - Skid buffer: 2 entries {data,last}, FIFO order; occ in {0,1,2}.
//   - in_ready = (occ != 2), decoded from flops only, with no combinational path from full or in_valid.
//   - Accept = in_valid & in_ready. Pop = w_en.
//   - Accept and pop in the same cycle: occ unchanged, order preserved.
// - Write: w_en = (occ != 0) & ~full. w_data = head.data. w_addr = w_count (passthrough).
//   - Latency: a word accepted in cycle t is written no earlier than t+1.
//   - full is updated by w_full on the same edge as the write, so no overwrite is possible.
// - Full boundary: while full=1, w_en=0 and occ fills to 2, then in_ready=0.
//   - When full drops, writes resume the next cycle with no lost or duplicated word.
// - CDC: rptr_gray passes through SYNC_STAGES flops; r_count_sync = last stage.
//   - Gray input makes each transition a single-bit change, so no bus skew handling is needed.
// - Packet FSM:
//   - IDLE: on w_en with head.last=0 -> PKT, len_cnt=1.
//   - IDLE: on w_en with head.last=1 -> stay in IDLE, pkt_done=1, pkt_len=1 (next edge).
//   - PKT: each w_en does len_cnt+1. On w_en with head.last -> IDLE, pkt_done=1, pkt_len=len_cnt+1.
//   - len_cnt saturates at 2^LEN_W-1. pkt_len holds its value until the next pkt_done.
// - Pointer wrap: handled by w_full. w_addr wraps 127->0 transparently.
// STRUCTURE
// - fifo_pkg:
//   - DATA_W/ADDR_W/PTR_W defaults.
//   - wr_state_t enum {IDLE,PKT}.
//   - gray2bin/bin2gray functions, shared with w_full and the read side.
// - Sub-module ptr_sync: parameterised PTR_W x SYNC_STAGES flop chain with async reset. Also reused for the wptr crossing into r_clk.
// - Top: skid buffer, write strobe decode, packet FSM, len counter.
// TESTING
// - Reset, then in_valid=1 for 1 word 0xA5 with last=1.
//   -> w_en high 1 cycle at w_addr=0 with w_data=0xA5.
//   -> pkt_done pulse on the next cycle, pkt_len=1.
// - Stream 10 words, last on word 10, full=0 throughout.
//   -> 10 consecutive w_en cycles, w_data in order, pkt_len=10.
// - Hold full=1 and push 3 words.
//   -> occ reaches 2, in_ready=0, word 3 held upstream, w_en=0.
//   -> Drop full: 3 writes in order over the next 3 cycles, none lost.
// - Drive rptr_gray 0x00->0x01 at an arbitrary phase.
//   -> r_count_sync = 0x01 exactly SYNC_STAGES w_clk edges later, never an intermediate value.
// - Pull n_rst low after 5 words of an unterminated packet.
//   -> All outputs at reset values, no pkt_done.
//   -> The next 2-word packet reports pkt_len=2.
// - Toggle full randomly with 1000 words across 7-word packets.
//   -> Scoreboard the data order, pkt_len=7 each time, and w_en=0 on every cycle where full=1.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the async FIFO write/read sides:
//               default widths, write-side packet FSM state type and the
//               gray/binary pointer conversion helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int c_data_w      = 8;   // RAM word width
  localparam int c_addr_w      = 7;   // RAM address width
  localparam int c_ptr_w       = 8;   // gray pointer width (address + wrap bit)
  localparam int c_sync_stages = 2;   // synchroniser depth
  localparam int c_len_w       = 16;  // packet length counter width

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } wr_state_t;

  function automatic logic [c_ptr_w-1:0] bin2gray(input logic [c_ptr_w-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at and above it.
  function automatic logic [c_ptr_w-1:0] gray2bin(input logic [c_ptr_w-1:0] gray);
    logic [c_ptr_w-1:0] bin;
    bin[c_ptr_w-1] = gray[c_ptr_w-1];
    for (int i = c_ptr_w - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : ptr_sync
// Description : Multi-flop synchroniser for a gray-coded pointer crossing
//               into the clk domain. Gray coding guarantees a single-bit
//               change per step, so the bus needs no skew handling.
// Ports       : clk   - destination clock
//               n_rst - async reset, active-low
//               d     - pointer from the source domain (async)
//               q     - synchronised pointer (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_sync #(
  parameter int PTR_W       = 8,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [PTR_W-1:0] d,
  output logic [PTR_W-1:0] q
);

  // Stage 0 captures the async input; higher index = older sample.
  logic [SYNC_STAGES-1:0][PTR_W-1:0] r_stage;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_stage[SYNC_STAGES-1];

endmodule : ptr_sync
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-side initiator of the async FIFO (w_clk domain).
//               Upstream words enter a 2-entry skid buffer via valid/ready,
//               are written to the dual-port RAM at the address supplied by
//               the full-flag block, and are framed into packets whose
//               length is reported with a one-cycle pkt_done pulse. Also
//               synchronises the read-side gray pointer into w_clk.
// Ports       : w_clk, n_rst           - clock, async active-low reset
//               in_valid/in_data/in_last/in_ready - upstream handshake
//               full, w_count           - from the full-flag block
//               rptr_gray               - read pointer (r_clk domain)
//               r_count_sync            - synchronised read pointer
//               w_en, w_addr, w_data    - RAM write port
//               pkt_done, pkt_len       - packet completion report
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W      = c_data_w,
  parameter int ADDR_W      = c_addr_w,
  parameter int PTR_W       = c_ptr_w,
  parameter int SYNC_STAGES = c_sync_stages,
  parameter int LEN_W       = c_len_w
) (
  input  logic              w_clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              full,
  input  logic [ADDR_W-1:0] w_count,
  input  logic [PTR_W-1:0]  rptr_gray,
  output logic [PTR_W-1:0]  r_count_sync,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len
);

  // --------------------------------------------------------------------------
  // Read pointer crossing
  // --------------------------------------------------------------------------
  ptr_sync #(
    .PTR_W       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (w_clk),
    .n_rst (n_rst),
    .d     (rptr_gray),
    .q     (r_count_sync)
  );

  // --------------------------------------------------------------------------
  // Skid buffer: head entry is always the next word to write
  // --------------------------------------------------------------------------
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_head_data;
  logic              r_head_last;
  logic [DATA_W-1:0] r_tail_data;
  logic              r_tail_last;

  logic w_accept;
  logic w_pop;
  logic w_load_tail;

  // in_ready depends only on r_occ so full/in_valid never reach it combinationally.
  assign in_ready = (r_occ != 2'd2);
  assign w_accept = in_valid & in_ready;
  assign w_pop    = w_en;

  // A new word lands in the tail only when the head stays occupied this cycle.
  assign w_load_tail = (r_occ == 2'd1) & ~w_pop;

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head_data <= r_tail_data;
        r_head_last <= r_tail_last;
      end
      if (w_accept) begin
        if (w_load_tail) begin
          r_tail_data <= in_data;
          r_tail_last <= in_last;
        end else begin
          // Overrides the shift above when accept and pop coincide at occ=1.
          r_head_data <= in_data;
          r_head_last <= in_last;
        end
      end
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RAM write port
  // --------------------------------------------------------------------------
  assign w_en   = (r_occ != 2'd0) & ~full;
  assign w_data = r_head_data;
  assign w_addr = w_count;

  // --------------------------------------------------------------------------
  // Packet framing FSM and length counter
  // --------------------------------------------------------------------------
  wr_state_t        r_state;
  logic [LEN_W-1:0] r_len_cnt;
  logic             r_pkt_done;
  logic [LEN_W-1:0] r_pkt_len;
  logic [LEN_W-1:0] w_len_inc;

  // Saturating increment keeps oversized packets from wrapping to small lengths.
  assign w_len_inc = (r_len_cnt == {LEN_W{1'b1}}) ? r_len_cnt : r_len_cnt + 1'b1;

  always_ff @(posedge w_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_len_cnt  <= '0;
      r_pkt_done <= 1'b0;
      r_pkt_len  <= '0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_en) begin
        case (r_state)
          IDLE: begin
            if (r_head_last) begin
              r_pkt_done <= 1'b1;
              r_pkt_len  <= LEN_W'(1);
            end else begin
              r_state   <= PKT;
              r_len_cnt <= LEN_W'(1);
            end
          end
          PKT: begin
            if (r_head_last) begin
              r_state    <= IDLE;
              r_len_cnt  <= '0;
              r_pkt_done <= 1'b1;
              r_pkt_len  <= w_len_inc;
            end else begin
              r_len_cnt <= w_len_inc;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign pkt_done = r_pkt_done;
  assign pkt_len  = r_pkt_len;

endmodule : fifo_wr_ctrl
`default_nettype wire
